// File: rtl/seg_display_scheduler_pkg.sv
// Shared definitions for the seven-segment display scheduler: blank code,
// FSM state encoding and a counter-width helper.
package seg_display_scheduler_pkg;

    // Digit code the display driver renders as a dash.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Four blank digits, digit_0 in the top nibble.
    localparam logic [15:0] BLANK_DIGITS = {4{BLANK_CODE}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } sched_state_e;

    // Width of a counter that must hold 0..value-1; never narrower than 1 bit.
    function automatic int cnt_width(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// Requester-side bus of the display scheduler.
// Optional blink request lines exist only when SEG_SCHED_BLINK_EN is defined.
//
// Handshake: a requester raises req[i] (level) with its digits on the
// matching req_data slice and keeps req[i] high until it either sees the
// one-cycle done[i] pulse or gives up; dropping req[i] while gnt[i] is high
// abandons the grant without a done pulse. gnt is one-hot or zero; busy
// mirrors "some grant is active". There is no backpressure on done.
interface seg_display_scheduler_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    done;
    logic                  busy;
`ifdef SEG_SCHED_BLINK_EN
    logic [NUM_REQ-1:0]    blink;
`endif

    // Requester side.
    modport master (
`ifdef SEG_SCHED_BLINK_EN
        output blink,
`endif
        output req, req_data,
        input  gnt, done, busy
    );

    // Scheduler side.
    modport slave (
`ifdef SEG_SCHED_BLINK_EN
        input  blink,
`endif
        input  req, req_data,
        output gnt, done, busy
    );
endinterface

// File: rtl/seg_display_scheduler_rr_pick.sv
// Combinational round-robin picker: the first set request searching upward
// from pointer+1, wrapping through 0 back to pointer itself.
module seg_display_scheduler_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    // Lowest set bit at or below the pointer, then overridden by the lowest
    // set bit above the pointer, which has the higher priority.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i <= int'(pointer))) begin
                winner    = '0;
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(pointer))) begin
                winner    = '0;
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Shares the 4-digit seven-segment display between NUM_REQ requesters with
// round-robin arbitration and a fixed on-screen hold per grant. Also emits a
// free-running scan clock-enable for the display multiplexer.
// Optional blinking of a granted requester's digits: SEG_SCHED_BLINK_EN.
module seg_display_scheduler
    import seg_display_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int SCAN_DIV    = 50_000,
    parameter int BLINK_DIV   = 250
) (
    input  logic                          clk,
    input  logic                          reset,
    seg_display_scheduler_if.slave        bus,
    output logic [3:0]                    digit_0,
    output logic [3:0]                    digit_1,
    output logic [3:0]                    digit_2,
    output logic [3:0]                    digit_3,
    output logic                          scan_tick,
    output sched_state_e                  state_dbg
);

    localparam int PTR_W  = cnt_width(NUM_REQ);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int SCAN_W = cnt_width(SCAN_DIV);

    sched_state_e        state, state_n;
    logic [PTR_W-1:0]    ptr, ptr_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    logic [NUM_REQ-1:0]  gnt_n, done_n;
    logic                busy_n;
    logic [15:0]         digits, digits_n;
    logic [SCAN_W-1:0]   scan_cnt;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic                pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic [PTR_W-1:0]    mux_idx;
    logic [15:0]         sel_slice;
    logic                sel_req;
    logic                force_blank;

    seg_display_scheduler_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req     (bus.req),
        .pointer (ptr),
        .winner  (pick_onehot),
        .valid   (pick_valid)
    );

    // Index of the freshly picked requester.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) pick_idx = PTR_W'(i);
        end
    end

    // In IDLE look at the candidate being granted; in SHOW the pointer is the winner.
    assign mux_idx = (state == ST_IDLE) ? pick_idx : ptr;

    // Select the request line and digit slice of the requester in focus.
    always_comb begin
        sel_slice = '0;
        sel_req   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mux_idx == PTR_W'(i)) begin
                sel_slice = bus.req_data[16*i +: 16];
                sel_req   = bus.req[i];
            end
        end
    end

`ifdef SEG_SCHED_BLINK_EN
    localparam int BLINK_W = cnt_width(BLINK_DIV);
    logic               blink_phase;
    logic [BLINK_W-1:0] blink_cnt;
    logic               sel_blink;

    // Blink request of the requester in focus.
    always_comb begin
        sel_blink = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mux_idx == PTR_W'(i)) sel_blink = bus.blink[i];
        end
    end

    // Blink phase toggles every BLINK_DIV scan ticks; starts in the "on" phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (scan_tick) begin
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign force_blank = sel_blink & ~blink_phase;
`else
    assign force_blank = 1'b0;
`endif

    // Next state and next registered outputs; every output defaults to idle/blank.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        hold_cnt_n = hold_cnt;
        gnt_n      = '0;
        done_n     = '0;
        busy_n     = 1'b0;
        digits_n   = BLANK_DIGITS;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_n    = ST_SHOW;
                    ptr_n      = pick_idx;
                    hold_cnt_n = HOLD_W'(HOLD_CYCLES - 1);
                    gnt_n      = pick_onehot;
                    busy_n     = 1'b1;
                    digits_n   = force_blank ? BLANK_DIGITS : sel_slice;
                end
            end
            ST_SHOW: begin
                if (!sel_req) begin
                    // Abandon wins over expiry: no done pulse.
                    state_n = ST_IDLE;
                end else if (hold_cnt == '0) begin
                    state_n = ST_IDLE;
                    done_n  = bus.gnt;
                end else begin
                    hold_cnt_n = hold_cnt - 1'b1;
                    gnt_n      = bus.gnt;
                    busy_n     = 1'b1;
                    digits_n   = force_blank ? BLANK_DIGITS : sel_slice;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM state, pointer, hold counter and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= PTR_W'(NUM_REQ - 1);
            hold_cnt <= '0;
            bus.gnt  <= '0;
            bus.done <= '0;
            bus.busy <= 1'b0;
            digits   <= BLANK_DIGITS;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_cnt_n;
            bus.gnt  <= gnt_n;
            bus.done <= done_n;
            bus.busy <= busy_n;
            digits   <= digits_n;
        end
    end

    // Free-running scan prescaler; first pulse on the SCAN_DIV-th clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            scan_tick <= 1'b0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            scan_tick <= 1'b1;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
            scan_tick <= 1'b0;
        end
    end

    assign digit_0   = digits[15:12];
    assign digit_1   = digits[11:8];
    assign digit_2   = digits[7:4];
    assign digit_3   = digits[3:0];
    assign state_dbg = state;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler (NUM_REQ=3, HOLD_CYCLES=8, SCAN_DIV=4).
module tb_seg_display_scheduler;
  import seg_display_scheduler_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int HOLD    = 8;
  localparam int SDIV    = 4;
  localparam logic [15:0] S0 = 16'h4567;
  localparam logic [15:0] S2 = 16'h89AB;

  logic clk;
  logic reset;
  logic [3:0] digit_0, digit_1, digit_2, digit_3;
  logic scan_tick;
  sched_state_e state_dbg;

  seg_display_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  seg_display_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .HOLD_CYCLES (HOLD),
    .SCAN_DIV    (SDIV),
    .BLINK_DIV   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .digit_0   (digit_0),
    .digit_1   (digit_1),
    .digit_2   (digit_2),
    .digit_3   (digit_3),
    .scan_tick (scan_tick),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;   // clock edges since the last reset release

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later; scan_tick checked against the cycle model.
  task automatic step();
    @(posedge clk);
    #1;
    if (!reset) begin
      cyc++;
      check("scan_tick", 32'(scan_tick), 32'((cyc % SDIV) == 0));
    end
  endtask

  task automatic check_outs(input string name, input logic [2:0] gnt, input logic [2:0] done,
                            input logic busy, input logic [15:0] dig);
    check({name, ".gnt"},    32'(bus.gnt), 32'(gnt));
    check({name, ".done"},   32'(bus.done), 32'(done));
    check({name, ".busy"},   32'(bus.busy), 32'(busy));
    check({name, ".digits"}, 32'({digit_0, digit_1, digit_2, digit_3}), 32'(dig));
    check({name, ".state"},  32'(state_dbg), 32'(busy ? ST_SHOW : ST_IDLE));
  endtask

  task automatic drive(input logic [2:0] req, input logic [15:0] s1);
    bus.req      = req;
    bus.req_data = {S2, s1, S0};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    cyc   = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [2:0]  req;
    logic [15:0] s1;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        busy;
    logic [15:0] dig;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] req, input logic [15:0] s1, input logic [2:0] gnt,
                              input logic [2:0] done, input logic busy, input logic [15:0] dig);
    vec_t v;
    v.req = req; v.s1 = s1; v.gnt = gnt; v.done = done; v.busy = busy; v.dig = dig;
    return v;
  endfunction

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
`ifdef SEG_SCHED_BLINK_EN
    bus.blink    = '0;
`endif
    reset = 1'b1;
    #1;
    check_outs("async_reset", 3'b000, 3'b000, 1'b0, 16'hFFFF);

    // Single grant of requester 1 with live digit updates, then expiry.
    vecs.push_back(mk(3'b010, 16'h0123, 3'b010, 3'b000, 1'b1, 16'h0123));
    vecs.push_back(mk(3'b010, 16'h0123, 3'b010, 3'b000, 1'b1, 16'h0123));
    vecs.push_back(mk(3'b010, 16'h0123, 3'b010, 3'b000, 1'b1, 16'h0123));
    vecs.push_back(mk(3'b010, 16'h0004, 3'b010, 3'b000, 1'b1, 16'h0004));
    vecs.push_back(mk(3'b010, 16'h0003, 3'b010, 3'b000, 1'b1, 16'h0003));
    vecs.push_back(mk(3'b010, 16'h0003, 3'b010, 3'b000, 1'b1, 16'h0003));
    vecs.push_back(mk(3'b010, 16'h0003, 3'b010, 3'b000, 1'b1, 16'h0003));
    vecs.push_back(mk(3'b010, 16'h0003, 3'b010, 3'b000, 1'b1, 16'h0003));
    vecs.push_back(mk(3'b010, 16'h0003, 3'b000, 3'b010, 1'b0, 16'hFFFF));
    vecs.push_back(mk(3'b000, 16'h0003, 3'b000, 3'b000, 1'b0, 16'hFFFF));
    // Requester 2 granted, abandons after three hold cycles.
    vecs.push_back(mk(3'b100, 16'h0003, 3'b100, 3'b000, 1'b1, S2));
    vecs.push_back(mk(3'b100, 16'h0003, 3'b100, 3'b000, 1'b1, S2));
    vecs.push_back(mk(3'b100, 16'h0003, 3'b100, 3'b000, 1'b1, S2));
    vecs.push_back(mk(3'b000, 16'h0003, 3'b000, 3'b000, 1'b0, 16'hFFFF));
    vecs.push_back(mk(3'b000, 16'h0003, 3'b000, 3'b000, 1'b0, 16'hFFFF));

    // Reset values and scan_tick cadence with no requests.
    do_reset();
    check_outs("reset", 3'b000, 3'b000, 1'b0, 16'hFFFF);
    for (int i = 0; i < 12; i++) begin
      step();
      check_outs("idle", 3'b000, 3'b000, 1'b0, 16'hFFFF);
    end

    // Table-driven single grant / live update / abandon.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].s1);
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].dig);
    end

    // Abandon on the expiry cycle: no done pulse.
    drive(3'b001, 16'h0003);
    for (int i = 0; i < HOLD; i++) begin
      step();
      check_outs("exp_abandon.hold", 3'b001, 3'b000, 1'b1, S0);
    end
    drive(3'b000, 16'h0003);
    step();
    check_outs("exp_abandon.drop", 3'b000, 3'b000, 1'b0, 16'hFFFF);
    step();
    check_outs("exp_abandon.after", 3'b000, 3'b000, 1'b0, 16'hFFFF);

    // Reset asserted mid-SHOW clears outputs without waiting for a clock edge.
    drive(3'b010, 16'h0123);
    repeat (3) step();
    check_outs("pre_reset", 3'b010, 3'b000, 1'b1, 16'h0123);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_outs("mid_show_reset", 3'b000, 3'b000, 1'b0, 16'hFFFF);
    check("mid_show_reset.scan", 32'(scan_tick), 32'd0);
    drive(3'b000, 16'h0123);
    do_reset();

    // All requesting: grant order 0,1,2,0 with a done/blank cycle between.
    drive(3'b111, 16'h0123);
    for (int g = 0; g < 4; g++) begin
      logic [2:0]  oh;
      logic [15:0] exp_dig;
      oh = 3'b001 << (g % 3);
      exp_dig = (g % 3 == 0) ? S0 : ((g % 3 == 1) ? 16'h0123 : S2);
      for (int c = 0; c < HOLD; c++) begin
        step();
        check_outs($sformatf("rr%0d.hold", g), oh, 3'b000, 1'b1, exp_dig);
      end
      step();
      check_outs($sformatf("rr%0d.done", g), 3'b000, oh, 1'b0, 16'hFFFF);
    end
    drive(3'b000, 16'h0123);
    step();
    check_outs("final_idle", 3'b000, 3'b000, 1'b0, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
